// File: rtl/song_pkg.sv
// Shared encodings for the song sequencer: play modes and FSM states.
package song_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_ONCE  = 2'b01;
  localparam logic [1:0] MODE_LEARN = 2'b10;
  localparam logic [1:0] MODE_LOOP  = 2'b11;

  // Modes with this bit set leave PLAY on their own; the others wait for a step pulse.
  localparam logic [1:0] PLAY_MODE = 2'b01;

  typedef enum logic [3:0] {
    StIdle,
    StLenRd,
    StLenWait,
    StFetch,
    StFetchWait,
    StPlay,
    StHold,
    StGap,
    StDone
  } state_e;

endpackage

// File: rtl/song_timer.sv
// Loadable down-counter shared by note duration and inter-note gap timing.
module song_timer #(
  parameter int unsigned DUR_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DUR_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DUR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// Multi-song player: reads length then notes from a shared ROM port and drives the buzzer.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned NUM_SONGS  = 3,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned NOTE_W     = 10,
  parameter int unsigned DUR_W      = 32,
  parameter int unsigned GAP_CYCLES = 10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic [1:0]        mode,
  input  logic              pause,
  input  logic              step,
  output logic              rom_en,
  output logic [SEL_W-1:0]  rom_song,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic [ADDR_W-1:0] cur_index,
  output logic              busy,
  output logic              done
);

  // Timer counts down to zero, so a load of N-1 spans N cycles.
  localparam logic [DUR_W-1:0] GapLoad = DUR_W'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [DUR_W-1:0]  tmr_val;
  logic              end_note, gap_done, sel_ok, sounding;

  assign sel_ok = (sel_q != '0) && (32'(sel_q) <= NUM_SONGS);

  song_timer #(
    .DUR_W(DUR_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .en_i       (tmr_en),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    note_d   = note_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    end_note = 1'b0;
    gap_done = 1'b0;

    unique case (state_q)
      StIdle:      if (sel_ok && mode_q != MODE_IDLE) state_d = StLenRd;
      StLenRd:     state_d = StLenWait;
      StLenWait: begin
        len_d = rom_note[ADDR_W-1:0];
        idx_d = ADDR_W'(1);
        if (rom_note[ADDR_W-1:0] == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch:     state_d = StFetchWait;
      StFetchWait: begin
        note_d   = rom_note;
        tmr_load = 1'b1;
        tmr_val  = (rom_dur == '0) ? '0 : rom_dur - DUR_W'(1);
        state_d  = StPlay;
      end
      StPlay: begin
        if (!pause) begin
          if (!tmr_zero) begin
            tmr_en = 1'b1;
          end else if ((mode_q & PLAY_MODE) != 2'b00) begin
            end_note = 1'b1;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold:      if (!pause && step) end_note = 1'b1;
      StGap: begin
        if (!pause) begin
          if (tmr_zero) gap_done = 1'b1;
          else          tmr_en   = 1'b1;
        end
      end
      StDone:      state_d = StDone;
      default:     state_d = StIdle;
    endcase

    if (end_note) begin
      if (GAP_CYCLES != 0) begin
        state_d  = StGap;
        tmr_load = 1'b1;
        tmr_val  = GapLoad;
      end else begin
        gap_done = 1'b1;
      end
    end

    if (gap_done) begin
      if (idx_q < len_q) begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = StFetch;
      end else begin
        done_d = 1'b1;
        if (mode_q == MODE_LOOP) begin
          idx_d   = ADDR_W'(1);
          state_d = StFetch;
        end else begin
          state_d = StDone;
        end
      end
    end

    // Any change of selection or mode abandons the song and restarts from IDLE.
    if (song_sel != sel_q || mode != mode_q) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      mode_q  <= MODE_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= song_sel;
      mode_q  <= mode;
      len_q   <= len_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    sounding   = (state_q inside {StPlay, StHold}) && !pause;
    busy       = !(state_q inside {StIdle, StDone});
    note_valid = sounding;
    note_out   = sounding ? note_q : '0;
    rom_en     = state_q inside {StLenRd, StFetch};
    rom_addr   = (state_q == StFetch) ? idx_q : '0;
    rom_song   = busy ? sel_q : '0;
    cur_index  = (state_q inside {StFetch, StFetchWait, StPlay, StHold, StGap}) ? idx_q : '0;
    done       = done_q;
  end

endmodule
